// File: rtl/gpr_wb_if.sv
// ---------------------------------------------------------------------------
// gpr_wb_if
// Bundles every signal of the GPR writeback controller except clk/rst_n.
//   ALU result : alu_valid, alu_ready, alu_rd, alu_data
//   LSU result : lsu_valid, lsu_ready, lsu_rd, lsu_data
//   Issue      : issue_en, issue_rd
//   Scoreboard : busy[NUM_REGS-1:0]
//   RF write   : reg_write_en, reg_wr_addr, reg_wr_data
//   Status     : addr_err (sticky out-of-range destination flag)
//   Forwarding : fwd_addr_1/2, fwd_hit_1/2, fwd_data_1/2
//                (present only when GPR_WB_FWD_EN is defined)
// Modports: master = producers/decode side, slave = the controller.
// ---------------------------------------------------------------------------
interface gpr_wb_if #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
);
    logic                alu_valid;
    logic                alu_ready;
    logic [ADDR_W-1:0]   alu_rd;
    logic [DATA_W-1:0]   alu_data;
    logic                lsu_valid;
    logic                lsu_ready;
    logic [ADDR_W-1:0]   lsu_rd;
    logic [DATA_W-1:0]   lsu_data;
    logic                issue_en;
    logic [ADDR_W-1:0]   issue_rd;
    logic [NUM_REGS-1:0] busy;
    logic                reg_write_en;
    logic [ADDR_W-1:0]   reg_wr_addr;
    logic [DATA_W-1:0]   reg_wr_data;
    logic                addr_err;
`ifdef GPR_WB_FWD_EN
    logic [ADDR_W-1:0]   fwd_addr_1;
    logic [ADDR_W-1:0]   fwd_addr_2;
    logic                fwd_hit_1;
    logic                fwd_hit_2;
    logic [DATA_W-1:0]   fwd_data_1;
    logic [DATA_W-1:0]   fwd_data_2;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_en, issue_rd,
`ifdef GPR_WB_FWD_EN
        output fwd_addr_1, fwd_addr_2,
        input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
`endif
        input  alu_ready, lsu_ready, busy,
        input  reg_write_en, reg_wr_addr, reg_wr_data, addr_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_en, issue_rd,
`ifdef GPR_WB_FWD_EN
        input  fwd_addr_1, fwd_addr_2,
        output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
`endif
        output alu_ready, lsu_ready, busy,
        output reg_write_en, reg_wr_addr, reg_wr_data, addr_err
    );
endinterface

// File: rtl/gpr_wb_ctrl.sv
// ---------------------------------------------------------------------------
// gpr_wb_ctrl
// Write-side controller for the general-purpose register file. Arbitrates
// ALU and LSU writeback results onto the single register-file write port
// (registered, one cycle latency) and keeps a busy-bit scoreboard of
// destinations issued but not yet written.
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : gpr_wb_if.slave (ALU/LSU handshakes, issue, busy, RF write,
//           addr_err, optional forwarding)
// Arbitration priority per cycle: LSU input, ALU skid buffer, ALU input.
// Optional feature macro: GPR_WB_FWD_EN adds a same-cycle forwarding
// compare of the write port against two decode read addresses.
// ---------------------------------------------------------------------------
module gpr_wb_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input logic    clk,
    input logic    rst_n,
    gpr_wb_if.slave bus
);
    // Highest legal destination; anything above it is out of range.
    localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(NUM_REGS - 1);

    logic                abuf_v;
    logic [ADDR_W-1:0]   abuf_rd;
    logic [DATA_W-1:0]   abuf_data;

    logic                lsu_acc;
    logic                alu_acc;
    logic                win_v;
    logic [ADDR_W-1:0]   win_rd;
    logic [DATA_W-1:0]   win_data;
    logic                win_in_range;
    logic                win_write;
    logic                issue_oor;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // The ALU may only hand over a result when the skid buffer is empty,
    // which keeps ALU results retiring in order.
    assign bus.alu_ready = rst_n && !abuf_v;
    assign bus.lsu_ready = rst_n;

    assign lsu_acc = bus.lsu_valid && bus.lsu_ready;
    assign alu_acc = bus.alu_valid && bus.alu_ready;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no
        // branch can leave it unassigned and infer a latch.
        win_v    = 1'b0;
        win_rd   = '0;
        win_data = '0;
        if (lsu_acc) begin
            win_v    = 1'b1;
            win_rd   = bus.lsu_rd;
            win_data = bus.lsu_data;
        end else if (abuf_v) begin
            win_v    = 1'b1;
            win_rd   = abuf_rd;
            win_data = abuf_data;
        end else if (alu_acc) begin
            win_v    = 1'b1;
            win_rd   = bus.alu_rd;
            win_data = bus.alu_data;
        end
    end

    // x0 and out-of-range winners complete their handshake but never write.
    assign win_in_range = (win_rd <= LAST_RD);
    assign win_write    = win_v && win_in_range && (win_rd != '0);
    assign issue_oor    = bus.issue_en && (bus.issue_rd > LAST_RD);

    // Scoreboard masks; bit 0 is never touched so x0 is never busy.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (bus.issue_en && (bus.issue_rd == ADDR_W'(i)))
                set_mask[i] = 1'b1;
            if (bus.reg_write_en && (bus.reg_wr_addr == ADDR_W'(i)))
                clr_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register
        // updates from the same pre-edge values regardless of order.
        if (!rst_n) begin
            abuf_v           <= 1'b0;
            bus.reg_write_en <= 1'b0;
            bus.reg_wr_addr  <= '0;
            bus.reg_wr_data  <= '0;
            bus.busy         <= '0;
            bus.addr_err     <= 1'b0;
        end else begin
            // Collision parks the ALU result; buffer drains on any cycle
            // without an LSU result and is starved while LSU keeps winning.
            if (lsu_acc && alu_acc)
                abuf_v <= 1'b1;
            else if (!lsu_acc)
                abuf_v <= 1'b0;

            bus.reg_write_en <= win_write;
            if (win_write) begin
                bus.reg_wr_addr <= win_rd;
                bus.reg_wr_data <= win_data;
            end

            // Set after clear: a newer producer of the same register wins.
            bus.busy <= (bus.busy & ~clr_mask) | set_mask;

            if ((win_v && !win_in_range) || issue_oor)
                bus.addr_err <= 1'b1;
        end
    end

    // NOTE: the buffer payload has no reset; it is only ever consumed
    // while abuf_v is set, and abuf_v itself is reset.
    always_ff @(posedge clk) begin
        if (lsu_acc && alu_acc) begin
            abuf_rd   <= bus.alu_rd;
            abuf_data <= bus.alu_data;
        end
    end

`ifdef GPR_WB_FWD_EN
    // Same-cycle bypass of the value currently on the write port.
    assign bus.fwd_hit_1  = bus.reg_write_en && (bus.reg_wr_addr == bus.fwd_addr_1)
                            && (bus.fwd_addr_1 != '0);
    assign bus.fwd_hit_2  = bus.reg_write_en && (bus.reg_wr_addr == bus.fwd_addr_2)
                            && (bus.fwd_addr_2 != '0);
    assign bus.fwd_data_1 = bus.fwd_hit_1 ? bus.reg_wr_data : '0;
    assign bus.fwd_data_2 = bus.fwd_hit_2 ? bus.reg_wr_data : '0;
`endif

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpr_wb_ctrl
// Directed testbench for gpr_wb_ctrl. A queue-based behavioural model
// predicts the write port, scoreboard, error flag and ready signals; a
// compare process checks them every cycle, and the directed sequence adds
// hand-computed literal expectations. Forwarding checks are compiled only
// when GPR_WB_FWD_EN is defined.
// ---------------------------------------------------------------------------
module tb_gpr_wb_ctrl;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gpr_wb_if #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    gpr_wb_ctrl #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: results waiting for the write slot sit in a
    // queue; each edge the oldest-by-priority candidate wins.
    // ------------------------------------------------------------------
    typedef struct {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t               pend_q[$];
    bit                model_valid = 1'b0;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    bit                m_hold_known;
    bit                m_busy[NUM_REGS];
    bit                m_err;

    task automatic model_edge();
        wb_t cand[$];
        wb_t w;
        bit  alu_taken;
        if (!rst_n) begin
            pend_q.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0; m_hold_known = 1'b1; m_err = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
            model_valid = 1'b1;
            return;
        end
        if (!model_valid) return;
        // Retire the write on the port this cycle, then record the new issue.
        if (m_we) m_busy[int'(m_addr)] = 1'b0;
        if (bus.issue_en) begin
            if (int'(bus.issue_rd) >= NUM_REGS) m_err = 1'b1;
            else if (bus.issue_rd != 0) m_busy[int'(bus.issue_rd)] = 1'b1;
        end
        alu_taken = bus.alu_valid && (pend_q.size() == 0);
        if (bus.lsu_valid) cand.push_back('{bus.lsu_rd, bus.lsu_data});
        while (pend_q.size() > 0) cand.push_back(pend_q.pop_front());
        if (alu_taken) cand.push_back('{bus.alu_rd, bus.alu_data});
        m_we = 1'b0;
        if (cand.size() > 0) begin
            w      = cand.pop_front();
            pend_q = cand;
            if (int'(w.rd) >= NUM_REGS) begin
                m_err = 1'b1; m_hold_known = 1'b0;
            end else if (w.rd == 0) begin
                m_hold_known = 1'b0;
            end else begin
                m_we = 1'b1; m_addr = w.rd; m_data = w.data; m_hold_known = 1'b1;
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin : compare
        logic [NUM_REGS-1:0] bv;
        if (model_valid) begin
            bv = '0;
            for (int i = 0; i < NUM_REGS; i++)
                if (m_busy[i]) bv = bv | (NUM_REGS'(1) << i);
            check("model_we", bus.reg_write_en, m_we);
            if (m_we || m_hold_known) begin
                check("model_addr", bus.reg_wr_addr, m_addr);
                check("model_data", bus.reg_wr_data, m_data);
            end
            check("model_busy", bus.busy, bv);
            check("model_addr_err", bus.addr_err, m_err);
            check("model_alu_ready", bus.alu_ready, rst_n && (pend_q.size() == 0));
            check("model_lsu_ready", bus.lsu_ready, rst_n);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change at negedge+1, model steps at posedge,
    // literal checks happen at the following negedge+1.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        bus.issue_en  = 1'b0;
    endtask

    task automatic alu(input int rd, input logic [DATA_W-1:0] d);
        bus.alu_valid = 1'b1; bus.alu_rd = ADDR_W'(rd); bus.alu_data = d;
    endtask

    task automatic lsu(input int rd, input logic [DATA_W-1:0] d);
        bus.lsu_valid = 1'b1; bus.lsu_rd = ADDR_W'(rd); bus.lsu_data = d;
    endtask

    task automatic issue(input int rd);
        bus.issue_en = 1'b1; bus.issue_rd = ADDR_W'(rd);
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        bus.alu_rd = '0; bus.alu_data = '0;
        bus.lsu_rd = '0; bus.lsu_data = '0; bus.issue_rd = '0;
`ifdef GPR_WB_FWD_EN
        bus.fwd_addr_1 = '0; bus.fwd_addr_2 = '0;
`endif
        alu(7, 32'hA5A5_A5A5);
        @(negedge clk); #1;

        // Reset held two cycles with an ALU result presented.
        step(); step();
        check("rst_we", bus.reg_write_en, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_alu_ready", bus.alu_ready, 0);
        rst_n = 1'b1; clr(); #1;
        check("release_alu_ready", bus.alu_ready, 1);

        // Single ALU write to r3 after issuing r3.
        issue(3); step(); clr();
        check("issue_busy3", bus.busy, 8'h08);
        alu(3, 32'hDEAD_BEEF); step(); clr();
        check("alu_we", bus.reg_write_en, 1);
        check("alu_addr", bus.reg_wr_addr, 3);
        check("alu_data", bus.reg_wr_data, 32'hDEAD_BEEF);
        check("alu_busy_pending", bus.busy, 8'h08);
        step();
        check("idle_we", bus.reg_write_en, 0);
        check("idle_busy", bus.busy, 0);
        check("idle_hold_addr", bus.reg_wr_addr, 3);

        // Collision: LSU takes the slot, ALU result parks in the buffer.
        issue(2); step(); issue(5); step(); clr();
        lsu(2, 32'h11); alu(5, 32'h22); step(); clr();
        check("col1_addr", bus.reg_wr_addr, 2);
        check("col1_data", bus.reg_wr_data, 32'h11);
        check("col1_alu_ready", bus.alu_ready, 0);
        step();
        check("col2_we", bus.reg_write_en, 1);
        check("col2_addr", bus.reg_wr_addr, 5);
        check("col2_data", bus.reg_wr_data, 32'h22);
        check("col2_alu_ready", bus.alu_ready, 1);
        check("col2_busy", bus.busy, 8'h20);
        step();
        check("col3_busy", bus.busy, 0);

        // Starvation: back-to-back LSU results hold off the buffered ALU
        // result while a further ALU result waits at the input.
        lsu(1, 32'h100); alu(6, 32'h200); step();
        lsu(7, 32'h300); alu(4, 32'h999); step();
        check("starve_addr", bus.reg_wr_addr, 7);
        check("starve_alu_ready", bus.alu_ready, 0);
        lsu(1, 32'h400); step();
        check("starve2_data", bus.reg_wr_data, 32'h400);
        bus.lsu_valid = 1'b0; step();
        check("drain_addr", bus.reg_wr_addr, 6);
        check("drain_data", bus.reg_wr_data, 32'h200);
        check("drain_alu_ready", bus.alu_ready, 1);
        step(); clr();
        check("order_addr", bus.reg_wr_addr, 4);
        check("order_data", bus.reg_wr_data, 32'h999);
        step();

        // x0 write: handshake completes, no register write.
        alu(0, 32'h55); step(); clr();
        check("x0_we", bus.reg_write_en, 0);
        check("x0_alu_ready", bus.alu_ready, 1);
        step();

        // Out-of-range LSU destination sets the sticky error.
        lsu(9, 32'h77); step(); clr();
        check("oor_we", bus.reg_write_en, 0);
        check("oor_err", bus.addr_err, 1);
        alu(1, 32'h88); step(); clr();
        check("oor_sticky_we", bus.reg_write_en, 1);
        check("oor_sticky_err", bus.addr_err, 1);
        step();

        // Scoreboard race: new issue of r4 while r4 is being written.
        issue(4); step(); clr();
        alu(4, 32'hCAFE); step(); clr();
        check("race_we", bus.reg_write_en, 1);
        check("race_addr", bus.reg_wr_addr, 4);
        issue(4); step(); clr();
        check("race_busy", bus.busy, 8'h10);
        step();
        check("race_busy_hold", bus.busy, 8'h10);

`ifdef GPR_WB_FWD_EN
        alu(6, 32'h1234); step(); clr();
        bus.fwd_addr_1 = 5'd6; bus.fwd_addr_2 = 5'd0; #1;
        check("fwd_hit_1", bus.fwd_hit_1, 1);
        check("fwd_data_1", bus.fwd_data_1, 32'h1234);
        check("fwd_hit_2", bus.fwd_hit_2, 0);
        check("fwd_data_2", bus.fwd_data_2, 0);
        bus.fwd_addr_1 = 5'd5; #1;
        check("fwd_miss_1", bus.fwd_hit_1, 0);
        step();
        check("fwd_idle_hit", bus.fwd_hit_1, 0);
`endif

        // Reset with a result parked in the buffer: it is discarded.
        lsu(3, 32'h1); alu(2, 32'h2); step();
        rst_n = 1'b0; clr(); step();
        check("midrst_we", bus.reg_write_en, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_err", bus.addr_err, 0);
        check("midrst_alu_ready", bus.alu_ready, 0);
        rst_n = 1'b1; step();
        check("midrst_discard_we", bus.reg_write_en, 0);

        // Out-of-range issue destination: error only, scoreboard untouched.
        issue(12); step(); clr();
        check("oor_issue_err", bus.addr_err, 1);
        check("oor_issue_busy", bus.busy, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wb_ctrl.md
Name: gpr_wb_ctrl

Overview:
- Write-side controller for the general-purpose register file.
- Accepts writeback results from the ALU and the load/store unit (LSU) over valid/ready handshakes and arbitrates between them.
- Drives the register file's single write port (enable/address/data) with registered outputs.
- Keeps a busy-bit scoreboard of destinations issued but not yet written, for hazard detection in decode.

Parameters:
- NUM_REGS, 8, number of implemented registers; addresses >= NUM_REGS are out of range.
- ADDR_W, 5, register address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- lsu_valid  in  1  LSU load result valid.
- lsu_ready  out  1  LSU accept; constant 1 outside reset.
- lsu_rd  in  ADDR_W  LSU destination register.
- lsu_data  in  DATA_W  LSU result.
- issue_en  in  1  decode issued an instruction writing issue_rd.
- issue_rd  in  ADDR_W  destination of the issued instruction.
- busy  out  NUM_REGS  scoreboard; bit i=1 means a write to register i is pending.
- reg_write_en  out  1  register file write enable.
- reg_wr_addr  out  ADDR_W  register file write address.
- reg_wr_data  out  DATA_W  register file write data.
- addr_err  out  1  sticky flag: an out-of-range destination was seen.

Behaviour:
- Reset, while rst_n=0 at a clock edge:
  - reg_write_en=0, reg_wr_addr=0, reg_wr_data=0.
  - busy=0, addr_err=0.
  - ALU skid buffer emptied; alu_ready=0 and lsu_ready=0 during the reset cycle.
  - A result in flight when reset asserts is discarded.
- ALU path:
  - One-entry skid buffer (abuf_v, abuf_rd, abuf_data).
  - alu_ready = rst_n && !abuf_v.
- Write-slot arbitration each cycle (one write per cycle), fixed priority:
  - 1st: LSU input.
  - 2nd: ALU buffer.
  - 3rd: ALU input.
- Ordering: while abuf_v=1, the ALU input cannot be accepted (alu_ready=0), so ALU results retire in order.
- Collision: if LSU and ALU input are accepted in the same cycle, LSU takes the slot and the ALU result goes into the buffer.
  - The buffer drains on the next cycle with no lsu_valid.
  - Consecutive lsu_valid cycles starve the buffer indefinitely; this is the intended behaviour.
- Latency: a result that wins the slot at edge N appears on reg_write_en/addr/data during cycle N..N+1, i.e. registered with 1 cycle of latency. The register file commits it at edge N+1.
- reg_write_en is 0 in any cycle with no winner; reg_wr_addr and reg_wr_data hold their previous values.
- Register x0: a winner with rd=0 completes its handshake but produces reg_write_en=0.
- Out-of-range destination (rd >= NUM_REGS):
  - Handshake completes, no write is issued, addr_err is set and stays set until reset.
  - Applies equally to an out-of-range issue_rd, which is ignored for the scoreboard.
- Scoreboard:
  - busy[issue_rd] is set at the edge where issue_en=1, if 0 < issue_rd < NUM_REGS.
  - busy[reg_wr_addr] is cleared at the edge ending a cycle with reg_write_en=1.
  - Set and clear of the same bit at the same edge: set wins, because a newer producer is outstanding.
  - busy[0] is always 0.
- The scoreboard does not count multiple outstanding writers. Decode must stall any issue whose rd is already busy (WAW); the controller does not check this.

Optional Feature:
- Macro: GPR_WB_FWD_EN.
- When defined, add these ports:
  - fwd_addr_1  in  ADDR_W; fwd_addr_2  in  ADDR_W.
  - fwd_hit_1  out  1; fwd_hit_2  out  1.
  - fwd_data_1  out  DATA_W; fwd_data_2  out  DATA_W.
- fwd_hit_k = reg_write_en && (reg_wr_addr == fwd_addr_k) && (fwd_addr_k != 0). This is combinational.
- fwd_data_k = reg_wr_data when fwd_hit_k=1, else 0.
- Purpose: lets decode see a value in the same cycle it is being written, before the register file read port reflects it.
- When not defined: the ports are absent and no compare logic is built.
- All other behaviour is identical with and without the macro.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with alu_valid=1 -> reg_write_en=0, busy=0, alu_ready=0. After release, alu_ready=1 in the first cycle.
- Single ALU write: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF at edge N -> during the next cycle reg_write_en=1, reg_wr_addr=3, reg_wr_data=0xDEADBEEF. busy[3] (set earlier via issue) clears at the following edge.
- Collision: LSU (rd=2, 0x11) and ALU (rd=5, 0x22) valid at the same edge -> cycle+1 writes r2=0x11 with alu_ready=0; cycle+2 writes r5=0x22; alu_ready returns to 1 in cycle+2.
- x0 and range: ALU rd=0 -> no reg_write_en, handshake done. LSU rd=9 -> no write, addr_err=1 and stays 1 through later traffic until rst_n=0.
- Scoreboard race: issue_en=1, issue_rd=4 in the same cycle that reg_write_en=1 with reg_wr_addr=4 -> busy[4]=1 after the edge.
- With GPR_WB_FWD_EN: reg_write_en=1, addr 6, data 0x1234, fwd_addr_1=6, fwd_addr_2=0 -> fwd_hit_1=1, fwd_data_1=0x1234, fwd_hit_2=0.
